req_client: RTL

REQ_CLIENT -- requirements
Module: req_client

---
 rtl/req_client.sv | 102 ++++++++++
 1 files changed

// File: rtl/req_client.sv
// Four-channel request client: per-channel FIFOs raise REQ toward an external arbiter,
// serve the granted channel, and track starvation, overflow and illegal grant codes.
module req_client #(
  parameter int unsigned DW         = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_LIM = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      push,
  input  logic [4*DW-1:0] push_data,
  output logic [3:0]      full,
  output logic [3:0]      REQ,
  input  logic [3:0]      GNT,
  output logic            out_valid,
  output logic [1:0]      out_ch,
  output logic [DW-1:0]   out_data,
  output logic [3:0]      starve,
  output logic [3:0]      ovf,
  output logic            gnt_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(STARVE_LIM + 1);

  localparam logic [AW-1:0] PtrMax  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CntFull = CW'(DEPTH);
  localparam logic [WW-1:0] WaitMax = WW'(STARVE_LIM);

  logic [DW-1:0] mem_q  [4][DEPTH];
  logic [AW-1:0] wptr_q [4];
  logic [AW-1:0] rptr_q [4];
  logic [CW-1:0] cnt_q  [4];
  logic [WW-1:0] wait_q [4];

  logic [3:0] push_ok;
  logic [3:0] serve;
  logic [1:0] serve_ch;
  logic       gnt_bad;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == PtrMax) ? '0 : p + AW'(1);
  endfunction

  // Status is derived from registered state only; a grant to an empty queue is ignored.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      full[i]    = (cnt_q[i] == CntFull);
      REQ[i]     = (cnt_q[i] != '0);
      starve[i]  = (wait_q[i] == WaitMax);
      push_ok[i] = push[i] & ~full[i];
      serve[i]   = (GNT == 4'(i + 1)) & REQ[i];
    end
  end

  assign gnt_bad  = (GNT > 4'd4);
  // Codes 1..4 map to channels 0..3; only meaningful when a serve is active.
  assign serve_ch = GNT[1:0] - 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]  <= '0;
        wptr_q[i] <= '0;
        rptr_q[i] <= '0;
        wait_q[i] <= '0;
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      ovf       <= '0;
      gnt_err   <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push_ok[i]) wptr_q[i] <= ptr_inc(wptr_q[i]);
        if (serve[i])   rptr_q[i] <= ptr_inc(rptr_q[i]);
        cnt_q[i] <= cnt_q[i] + CW'(push_ok[i]) - CW'(serve[i]);
        if (push[i] && full[i]) ovf[i] <= 1'b1;
        if (serve[i] || !REQ[i]) begin
          wait_q[i] <= '0;
        end else if (!starve[i]) begin
          wait_q[i] <= wait_q[i] + WW'(1);
        end
      end
      out_valid <= |serve;
      if (|serve) begin
        out_ch   <= serve_ch;
        out_data <= mem_q[serve_ch][rptr_q[serve_ch]];
      end
      if (gnt_bad) gnt_err <= 1'b1;
    end
  end

  // Storage is not reset; pointers and counts define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (push_ok[i]) mem_q[i][wptr_q[i]] <= push_data[i*DW +: DW];
    end
  end

endmodule
